dmem_arbiter: RTL and testbench

Shares the single synchronous data-memory port between the CPU's MEM-stage access and a secondary debug/DMA requester. The CPU path has absolute priority and is a zero-latency combinational pass-through, because the pipeline cannot be stalled by memory. Secondary requests are buffered in a one-entry holding register and issued only in cycles where the CPU drives neither read nor write. The block sits between the CPU data-memory outputs and the data memory.

---
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU pass-through with absolute priority, one-entry debug/DMA holding slot.
// Optional starvation flag built when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wrdata,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic        dbg_write,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wrdata,
    input  logic [3:0]  dbg_sign_mask,
    output logic        dbg_done,
    output logic [31:0] dbg_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_rddata,
    output logic        cpu_stall_req
);

    typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_hold_write;
    logic [31:0] r_hold_addr;
    logic [31:0] r_hold_wrdata;
    logic [3:0]  r_hold_mask;

    logic w_cpu_active;
    logic w_issue;

    assign w_cpu_active = cpu_memread | cpu_memwrite;
    assign w_issue      = (r_state == PEND) && !w_cpu_active;

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        mem_addr      = '0;
        mem_wrdata    = '0;
        mem_memwrite  = 1'b0;
        mem_memread   = 1'b0;
        mem_sign_mask = '0;
        if (w_cpu_active) begin
            mem_addr      = cpu_addr;
            mem_wrdata    = cpu_wrdata;
            mem_memwrite  = cpu_memwrite;
            mem_memread   = cpu_memread;
            mem_sign_mask = cpu_sign_mask;
        end else if (w_issue) begin
            mem_addr      = r_hold_addr;
            mem_wrdata    = r_hold_wrdata;
            mem_memwrite  = r_hold_write;
            mem_memread   = !r_hold_write;
            mem_sign_mask = r_hold_mask;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    // NOTE: the holding register is reset too, so nothing stale can ever be issued after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
            r_rdata       <= '0;
            r_hold_write  <= 1'b0;
            r_hold_addr   <= '0;
            r_hold_wrdata <= '0;
            r_hold_mask   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dbg_valid) begin
                        r_hold_write  <= dbg_write;
                        r_hold_addr   <= dbg_addr;
                        r_hold_wrdata <= dbg_wrdata;
                        r_hold_mask   <= dbg_sign_mask;
                        r_state       <= PEND;
                        r_ready       <= 1'b0;
                    end
                end
                PEND: begin
                    if (!w_cpu_active) begin
                        if (r_hold_write) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    // Read data from the issue cycle arrives now.
                    r_rdata <= mem_rddata;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign dbg_ready = r_ready;
    assign dbg_done  = r_done;
    assign dbg_rdata = r_rdata;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [8:0] LIMIT9 = 9'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;
    logic       r_stall;
    logic [8:0] w_cnt_inc;

    assign w_cnt_inc = {1'b0, r_starve_cnt} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
        end else if ((r_state == PEND) && w_cpu_active) begin
            r_starve_cnt <= w_cnt_inc[8] ? 8'hFF : w_cnt_inc[7:0];
            if (w_cnt_inc >= LIMIT9) r_stall <= 1'b1;
        end else begin
            r_starve_cnt <= '0;
            if (w_issue) r_stall <= 1'b0;
        end
    end

    assign cpu_stall_req = r_stall;
`else
    logic w_unused_starve;
    assign w_unused_starve = (STARVE_LIMIT != 0);
    assign cpu_stall_req   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (STARVE_LIMIT = 4).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wrdata;
    logic        cpu_memwrite, cpu_memread;
    logic [3:0]  cpu_sign_mask;
    logic        dbg_valid, dbg_ready, dbg_write, dbg_done;
    logic [31:0] dbg_addr, dbg_wrdata, dbg_rdata;
    logic [3:0]  dbg_sign_mask;
    logic [31:0] mem_addr, mem_wrdata, mem_rddata;
    logic        mem_memwrite, mem_memread;
    logic [3:0]  mem_sign_mask;
    logic        cpu_stall_req;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [31:0] EXP_STALL = 32'd1;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
        .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
        .cpu_sign_mask(cpu_sign_mask),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_write(dbg_write),
        .dbg_addr(dbg_addr), .dbg_wrdata(dbg_wrdata), .dbg_sign_mask(dbg_sign_mask),
        .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask), .mem_rddata(mem_rddata),
        .cpu_stall_req(cpu_stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        cpu_memread   = rd;
        cpu_memwrite  = wr;
        cpu_addr      = a;
        cpu_wrdata    = d;
        cpu_sign_mask = m;
    endtask

    task automatic dbg_set(input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        dbg_valid     = v;
        dbg_write     = w;
        dbg_addr      = a;
        dbg_wrdata    = d;
        dbg_sign_mask = m;
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_rddata = '0;
        cpu_set(0, 0, 0, 0, 0);
        dbg_set(0, 0, 0, 0, 0);

        // Reset values
        #12;
        check("rst_ready",  32'(dbg_ready), 32'd1);
        check("rst_done",   32'(dbg_done), 32'd0);
        check("rst_rdata",  dbg_rdata, 32'd0);
        check("rst_rd",     32'(mem_memread), 32'd0);
        check("rst_wr",     32'(mem_memwrite), 32'd0);
        check("rst_stall",  32'(cpu_stall_req), 32'd0);
        rst_n = 1'b1;

        // CPU-only store passes straight through
        tick();
        cpu_set(0, 1, 32'h100, 32'hDEADBEEF, 4'hF);
        #1;
        check("cpu_wr",    32'(mem_memwrite), 32'd1);
        check("cpu_addr",  mem_addr, 32'h100);
        check("cpu_data",  mem_wrdata, 32'hDEADBEEF);
        check("cpu_mask",  32'(mem_sign_mask), 32'hF);
        check("cpu_ready", 32'(dbg_ready), 32'd1);
        tick();
        check("cpu_ready2", 32'(dbg_ready), 32'd1);
        cpu_set(0, 0, 0, 0, 0);
        #1;
        check("idle_addr", mem_addr, 32'd0);

        // Idle-bus debug load at 0x200
        dbg_set(1, 0, 32'h200, 32'h0, 4'hF);
        tick();                                   // edge A
        dbg_set(0, 0, 0, 0, 0);
        check("ld_rd_A1",    32'(mem_memread), 32'd1);
        check("ld_addr_A1",  mem_addr, 32'h200);
        check("ld_ready_A1", 32'(dbg_ready), 32'd0);
        tick();                                   // A+2 (RESP)
        mem_rddata = 32'h12345678;
        #1;
        check("ld_rd_A2",    32'(mem_memread), 32'd0);
        check("ld_done_A2",  32'(dbg_done), 32'd0);
        tick();                                   // A+3
        mem_rddata = '0;
        check("ld_done_A3",  32'(dbg_done), 32'd1);
        check("ld_rdata_A3", dbg_rdata, 32'h12345678);
        check("ld_ready_A3", 32'(dbg_ready), 32'd1);
        tick();
        check("ld_done_A4",  32'(dbg_done), 32'd0);
        check("ld_rdata_hold", dbg_rdata, 32'h12345678);

        // Debug store delayed by 3 CPU-busy cycles
        dbg_set(1, 1, 32'h300, 32'hCAFEF00D, 4'h3);
        tick();                                   // edge A
        dbg_set(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cpu_set(1, 0, 32'h400 + 32'(i), 32'h0, 4'hF);
            #1;
            check("busy_rd",   32'(mem_memread), 32'd1);
            check("busy_wr",   32'(mem_memwrite), 32'd0);
            check("busy_addr", mem_addr, 32'h400 + 32'(i));
            tick();
        end
        cpu_set(0, 0, 0, 0, 0);                   // A+4
        #1;
        check("st_wr_A4",    32'(mem_memwrite), 32'd1);
        check("st_addr_A4",  mem_addr, 32'h300);
        check("st_data_A4",  mem_wrdata, 32'hCAFEF00D);
        check("st_mask_A4",  32'(mem_sign_mask), 32'h3);
        check("st_done_A4",  32'(dbg_done), 32'd0);
        check("st_stall_A4", 32'(cpu_stall_req), 32'd0);
        tick();                                   // A+5
        check("st_done_A5",  32'(dbg_done), 32'd1);
        check("st_ready_A5", 32'(dbg_ready), 32'd1);
        check("st_wr_A5",    32'(mem_memwrite), 32'd0);
        check("st_rdata",    dbg_rdata, 32'h12345678);

        // Starvation: CPU busy continuously, limit 4
        dbg_set(1, 1, 32'h500, 32'h55, 4'hF);
        tick();                                   // edge A
        dbg_set(0, 0, 0, 0, 0);
        cpu_set(0, 1, 32'h900, 32'h1, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            check("stv_low", 32'(cpu_stall_req), 32'd0);
            tick();
        end
        check("stv_high_A5", 32'(cpu_stall_req), EXP_STALL);
        tick();
        cpu_set(0, 0, 0, 0, 0);                   // issue cycle A+6
        #1;
        check("stv_issue_wr",   32'(mem_memwrite), 32'd1);
        check("stv_issue_addr", mem_addr, 32'h500);
        check("stv_high_A6",    32'(cpu_stall_req), EXP_STALL);
        tick();
        check("stv_low_A7",  32'(cpu_stall_req), 32'd0);
        check("stv_done_A7", 32'(dbg_done), 32'd1);

        // Reset during RESP aborts the load
        dbg_set(1, 0, 32'h600, 32'h0, 4'hF);
        tick();
        dbg_set(0, 0, 0, 0, 0);
        check("rr_rd_A1", 32'(mem_memread), 32'd1);
        tick();                                   // RESP
        mem_rddata = 32'hAAAA5555;
        #1;
        rst_n = 1'b0;
        #1;
        check("rr_ready", 32'(dbg_ready), 32'd1);
        check("rr_done",  32'(dbg_done), 32'd0);
        check("rr_rdata", dbg_rdata, 32'd0);
        check("rr_rd",    32'(mem_memread), 32'd0);
        tick();
        check("rr_done_hold", 32'(dbg_done), 32'd0);
        rst_n = 1'b1;
        mem_rddata = '0;
        tick();
        check("rr_done_rel",  32'(dbg_done), 32'd0);
        check("rr_ready_rel", 32'(dbg_ready), 32'd1);
        check("rr_rdata_rel", dbg_rdata, 32'd0);
        check("rr_rd_rel",    32'(mem_memread), 32'd0);

        // Back-to-back loads with dbg_valid held high
        dbg_set(1, 0, 32'h700, 32'h0, 4'hF);
        tick();                                   // edge A: first accepted
        dbg_addr = 32'h704;
        #1;
        check("bb_rd_A1",    32'(mem_memread), 32'd1);
        check("bb_addr_A1",  mem_addr, 32'h700);
        tick();                                   // A+2
        mem_rddata = 32'h11111111;
        #1;
        check("bb_ready_A2", 32'(dbg_ready), 32'd0);
        tick();                                   // A+3
        mem_rddata = '0;
        check("bb_done1",    32'(dbg_done), 32'd1);
        check("bb_rdata1",   dbg_rdata, 32'h11111111);
        check("bb_ready_A3", 32'(dbg_ready), 32'd1);
        check("bb_rd_A3",    32'(mem_memread), 32'd0);
        tick();                                   // edge B: second accepted
        dbg_set(0, 0, 0, 0, 0);
        #1;
        check("bb_done_B1",  32'(dbg_done), 32'd0);
        check("bb_addr_B1",  mem_addr, 32'h704);
        check("bb_ready_B1", 32'(dbg_ready), 32'd0);
        tick();
        mem_rddata = 32'h22222222;
        tick();
        mem_rddata = '0;
        check("bb_done2",    32'(dbg_done), 32'd1);
        check("bb_rdata2",   dbg_rdata, 32'h22222222);
        tick();
        check("bb_idle_ready", 32'(dbg_ready), 32'd1);
        check("bb_idle_rd",    32'(mem_memread), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
